// File: rtl/uart_rx.sv
// uart_rx -- receive half of the 8-bit UART (1 start, 8 data LSB-first, 1 stop, no parity).
// The serial line is synchronized, oversampled 16x and decoded by a small FSM into
// parallel bytes with one-cycle valid/error strobes.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of the
// samples at ticks 7, 8 and 9, and the decision moves to tick 9. When the macro is
// undefined, the single sample at tick 8 decides the bit.
module uart_rx #(
   parameter int baud_rate  = 9600,
   parameter int clock_freq = 10000000
) (
   input  logic       uart_clock,
   input  logic       uart_reset,
   input  logic       uart_d_in,
   output logic [7:0] uart_d_out,
   output logic       uart_rx_valid,
   output logic       uart_rx_error,
   output logic       uart_rx_busy
);

   // Prescaler divide ratio: integer division, never below 1.
   localparam int DIV_RAW = clock_freq / (baud_rate * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

`ifdef UART_RX_MAJORITY_EN
   localparam logic [3:0] DECIDE_T = 4'd9;
`else
   localparam logic [3:0] DECIDE_T = 4'd8;
`endif

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   state_t          state;
   logic            sync_p0;
   logic            sync_p1;
   logic [1:0]      fill;
   logic            armed;
   logic [PW-1:0]   presc;
   logic            tick;
   logic [3:0]      tick_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic            rx_s;
   logic            bit_val;
   logic            decide;
   logic            start_det;

   assign rx_s = sync_p1;

   // Two-flop synchronizer for the asynchronous line; fill marks when the reset
   // value of the synchronizer has been flushed so it cannot arm the receiver.
   always_ff @(posedge uart_clock) begin
      if (uart_reset) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
         fill    <= 2'b00;
      end else begin
         sync_p0 <= uart_d_in;
         sync_p1 <= sync_p0;
         fill    <= {fill[0], 1'b1};
      end
   end

   assign start_det = (state == IDLE) && armed && !rx_s;
   assign tick      = (presc == PMAX);
   assign decide    = tick && (tick_cnt == DECIDE_T);

   // 16x prescaler; restarted on start detection so ticks align to the falling edge.
   always_ff @(posedge uart_clock) begin
      if (uart_reset || start_det || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic maj_7;
   logic maj_8;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Capture the early samples of the majority window.
   always_ff @(posedge uart_clock) begin
      if (tick && (tick_cnt == 4'd7)) maj_7 <= rx_s;
      if (tick && (tick_cnt == 4'd8)) maj_8 <= rx_s;
   end

   assign bit_val = maj3(maj_7, maj_8, rx_s);
`else
   assign bit_val = rx_s;
`endif

   // Receive FSM with registered data, strobes and busy flag.
   always_ff @(posedge uart_clock) begin
      if (uart_reset) begin
         state         <= IDLE;
         armed         <= 1'b0;
         tick_cnt      <= 4'd0;
         bit_cnt       <= 3'd0;
         shift         <= 8'h00;
         uart_d_out    <= 8'h00;
         uart_rx_valid <= 1'b0;
         uart_rx_error <= 1'b0;
         uart_rx_busy  <= 1'b0;
      end else begin
         uart_rx_valid <= 1'b0;
         uart_rx_error <= 1'b0;
         if (tick) tick_cnt <= tick_cnt + 4'd1;
         case (state)
            IDLE: begin
               uart_rx_busy <= 1'b0;
               if (start_det) begin
                  tick_cnt <= 4'd0;
                  armed    <= 1'b0;
                  state    <= START;
               end else if (rx_s && fill[1]) begin
                  // Only a genuinely high line arms the receiver, so a frame that
                  // was already running when reset released is ignored.
                  armed <= 1'b1;
               end
            end
            START: begin
               if (decide) begin
                  if (bit_val) begin
                     armed <= 1'b1;
                     state <= IDLE;
                  end else begin
                     uart_rx_busy <= 1'b1;
                  end
               end else if (tick && (tick_cnt == 4'd15)) begin
                  tick_cnt <= 4'd0;
                  bit_cnt  <= 3'd0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (decide) shift <= {bit_val, shift[7:1]};
               if (tick && (tick_cnt == 4'd15)) begin
                  tick_cnt <= 4'd0;
                  if (bit_cnt == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            STOP: begin
               if (decide) begin
                  if (bit_val) begin
                     uart_d_out    <= shift;
                     uart_rx_valid <= 1'b1;
                     uart_rx_busy  <= 1'b0;
                     armed         <= 1'b1;
                     state         <= IDLE;
                  end else begin
                     uart_rx_error <= 1'b1;
                     state         <= WAIT_IDLE;
                  end
               end
            end
            WAIT_IDLE: begin
               // Break or stuck-low line: hold busy until the line recovers.
               if (rx_s) begin
                  uart_rx_busy <= 1'b0;
                  armed        <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed self-checking bench for uart_rx.
// Runs with a reduced clock frequency (DIV = 16, one bit = 256 clocks) so that
// every scenario fits in a short run; expected values are hand-computed below.
module tb_uart_rx;

   localparam int BAUD   = 9600;
   localparam int CLK_HZ = 2500000;   // 2500000 / 153600 = 16.27 -> DIV = 16
   localparam int DIV    = 16;
   localparam int BIT    = 256;       // 16 ticks * 16 clocks
   localparam int LAT_LO = 9 * BIT + BIT / 2;
   localparam int LAT_HI = LAT_LO + 2 * DIV + 8;
   localparam int GOFF   = 136;       // glitch covers only the tick-8 sample point
   localparam int GLEN   = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       d_in;
   logic [7:0] d_out;
   logic       valid;
   logic       err;
   logic       busy;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_err = 0;
   int n_busy = 0;
   int n_both = 0;
   int vt [16];
   logic [7:0] vd [16];
   int t_frame;

   uart_rx #(.baud_rate(BAUD), .clock_freq(CLK_HZ)) dut (
      .uart_clock   (clk),
      .uart_reset   (rst),
      .uart_d_in    (d_in),
      .uart_d_out   (d_out),
      .uart_rx_valid(valid),
      .uart_rx_error(err),
      .uart_rx_busy (busy)
   );

   always #5 clk = ~clk;

   // Cycle counter used for timing measurements.
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor sampled on the falling edge.
   always @(negedge clk) begin
      if (valid) begin
         if (n_valid < 16) begin
            vt[n_valid] <= cyc;
            vd[n_valid] <= d_out;
         end
         n_valid <= n_valid + 1;
      end
      if (err) n_err <= n_err + 1;
      if (busy) n_busy <= n_busy + 1;
      if (valid && err) n_both <= n_both + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one frame; gbit selects a frame bit (0 = start) that gets a short low glitch.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int gbit);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      t_frame = cyc;
      for (int i = 0; i < 10; i++) begin
         d_in = f[i];
         if (i == gbit) begin
            step(GOFF);
            d_in = 1'b0;
            step(GLEN);
            d_in = f[i];
            step(BIT - GOFF - GLEN);
         end else begin
            step(BIT);
         end
      end
   endtask

   initial begin
      int ta, v0, e0, b0, lat;
      rst  = 1'b1;
      d_in = 1'b1;
      step(4);
      chk("rst_d_out", d_out, 8'h00);
      chk("rst_valid", valid, 0);
      chk("rst_error", err, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      // Idle line
      step(2000);
      chk("idle_busy_cycles", n_busy, 0);
      chk("idle_valid", n_valid, 0);
      chk("idle_error", n_err, 0);
      chk("idle_d_out", d_out, 8'h00);

      // Back-to-back frames
      send_frame(8'hA5, 1'b1, -1);
      ta = t_frame;
      send_frame(8'h5A, 1'b1, -1);
      step(8);
      chk("b2b_count", n_valid, 2);
      chk("b2b_byte0", vd[0], 8'hA5);
      chk("b2b_byte1", vd[1], 8'h5A);
      chk("b2b_gap", vt[1] - vt[0], 10 * BIT);
      lat = vt[0] - ta;
      chk("b2b_latency_in_window", (lat >= LAT_LO) && (lat <= LAT_HI), 1);
      chk("b2b_d_out", d_out, 8'h5A);
      chk("b2b_error", n_err, 0);

      // Framing error followed by a break, then a good frame
      v0 = n_valid;
      send_frame(8'h3C, 1'b0, -1);
      step(3000);
      chk("ferr_count", n_err, 1);
      chk("ferr_no_valid", n_valid, v0);
      chk("ferr_d_out_held", d_out, 8'h5A);
      chk("ferr_busy_in_break", busy, 1);
      d_in = 1'b1;
      step(6);
      chk("ferr_busy_released", busy, 0);
      chk("ferr_single_pulse", n_err, 1);
      send_frame(8'h81, 1'b1, -1);
      step(8);
      chk("after_ferr_count", n_valid, v0 + 1);
      chk("after_ferr_byte", vd[v0], 8'h81);

      // Short low glitch on the idle line
      v0 = n_valid;
      e0 = n_err;
      b0 = n_busy;
      d_in = 1'b0;
      step(49);
      d_in = 1'b1;
      step(BIT);
      chk("glitch_valid", n_valid, v0);
      chk("glitch_error", n_err, e0);
      chk("glitch_busy_cycles", n_busy - b0, 0);
      chk("glitch_busy", busy, 0);

      // Reset in the middle of a frame whose line stays low afterwards
      v0 = n_valid;
      e0 = n_err;
      d_in = 1'b0;
      step(5 * BIT + BIT / 2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("midrst_d_out", d_out, 8'h00);
      chk("midrst_valid", valid, 0);
      chk("midrst_error", err, 0);
      chk("midrst_busy", busy, 0);
      b0 = n_busy;
      step(3 * BIT);
      d_in = 1'b1;
      step(2 * BIT);
      chk("midrst_no_valid", n_valid, v0);
      chk("midrst_no_error", n_err, e0);
      chk("midrst_busy_cycles", n_busy - b0, 0);
      send_frame(8'h42, 1'b1, -1);
      step(8);
      chk("post_rst_count", n_valid, v0 + 1);
      chk("post_rst_byte", vd[v0], 8'h42);
      chk("post_rst_d_out", d_out, 8'h42);

`ifdef UART_RX_MAJORITY_EN
      // One-tick glitch at data bit 3 sample point is voted out
      v0 = n_valid;
      e0 = n_err;
      send_frame(8'hFF, 1'b1, 4);
      step(8);
      chk("maj_count", n_valid, v0 + 1);
      chk("maj_byte", vd[v0], 8'hFF);
      chk("maj_error", n_err, e0);
`endif

      chk("valid_error_exclusive", n_both, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the 8-bit UART: recovers bytes from the asynchronous serial line and presents them as parallel data with a one-cycle valid strobe. It mirrors `uart_tx`: same baud/clock parameters and frame format (1 start, 8 data LSB-first, 1 stop, no parity). It sits between the device's serial input pin and the byte consumer, typically a loopback or command decoder.

## Interface

- `baud_rate`, 9600, line bit rate in bits/s.
- `clock_freq`, 10000000, `uart_clock` frequency in Hz.
- `uart_clock` input 1: system clock; all logic on the rising edge.
- `uart_reset` input 1: synchronous, active-high reset.
- `uart_d_in` input 1: asynchronous serial line; idles high.
- `uart_d_out` output 8: last correctly framed byte; holds until the next good byte.
- `uart_rx_valid` output 1: one-cycle pulse when `uart_d_out` updates.
- `uart_rx_error` output 1: one-cycle pulse on framing error (stop bit sampled 0).
- `uart_rx_busy` output 1: high from accepted start bit until the FSM returns to IDLE.

## Operation

- `uart_d_in` passes through a 2-flop synchronizer. All decisions use the synchronized value `rx_s`.
- Oversampling is 16x. `DIV = clock_freq / (baud_rate*16)` uses integer division, with a minimum of 1. The prescaler counts 0..DIV-1 and emits `tick` when it wraps. It is cleared on start detection so ticks align to the falling edge.
- `tick_cnt` is a 4-bit counter of ticks within the current bit. `bit_cnt` is 3 bits. `shift` is 8 bits and fills LSB first (right-shift, new bit in at bit 7).
- IDLE:
  - Outputs quiet, `busy` = 0.
  - When `rx_s` = 0: clear the prescaler and `tick_cnt`, then go to START.
- START:
  - Sample at mid-bit (see Configuration).
  - Sample = 1: false start; return to IDLE with no pulse.
  - Sample = 0: `busy` = 1; when `tick_cnt` reaches 15, clear `tick_cnt`, set `bit_cnt` = 0, go to DATA.
- DATA:
  - Sample at mid-bit and shift the value into `shift`.
  - At `tick_cnt` = 15: if `bit_cnt` = 7, go to STOP; otherwise increment `bit_cnt`.
- STOP:
  - Sample at mid-bit.
  - Sample = 1: `uart_d_out` <= `shift`, pulse `uart_rx_valid`, go to IDLE at that decision.
  - Sample = 0: pulse `uart_rx_error`, leave `uart_d_out` unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until `rx_s` = 1 (break or stuck-low line), then go to IDLE.
  - `busy` stays 1.
- `valid` and `error` are never high in the same cycle.

## Timing

- Reset values: `uart_d_out` = 8'h00; `uart_rx_valid`, `uart_rx_error`, `uart_rx_busy` = 0. FSM = IDLE; prescaler, `tick_cnt`, `bit_cnt`, `shift` = 0; synchronizer flops = 1.
- Reset asserted mid-frame aborts immediately: no pulse is emitted and the FSM returns to IDLE. A frame already in progress when reset deasserts is ignored until the line has been seen high (IDLE requires a 1→0 edge: IDLE arms only after `rx_s` = 1 has been observed once).
- Synchronizer latency is 2 clocks.
- Mid-bit sample decision is at `tick_cnt` = 8 of each bit (9 with majority, see Configuration).
- `uart_rx_valid` rises on the clock after the stop-bit decision, about 9.5 bit times plus 3 clocks after the line's falling edge. At defaults, 1 bit = 16*65 = 1040 clocks.
- A new start bit may begin immediately after the stop bit's mid-point. IDLE accepts a falling edge on the cycle after `valid`.
- Pulses last exactly one `uart_clock` cycle regardless of `DIV`.

## Configuration

- Macro: `UART_RX_MAJORITY_EN`.
- Defined:
  - Each bit value is the 2-of-3 majority of `rx_s` sampled at ticks 7, 8 and 9.
  - The decision (and shift/valid/error) happens at tick 9.
  - A single-tick glitch inside the window is rejected.
- Undefined:
  - A single sample at tick 8 decides the bit.
  - Majority registers are not instantiated.

## Test plan

- Reset then idle line high for 2000 clocks → all outputs 0, `busy` never rises.
- Send 8'hA5 (one frame, defaults) → exactly one `uart_rx_valid` pulse, `uart_d_out` = 8'hA5, `error` = 0.
- Back-to-back 8'hA5 then 8'h5A with no idle gap → two `valid` pulses about 10400 clocks apart, outputs 8'hA5 then 8'h5A.
- 0x3C frame with stop bit forced 0, line held low 3000 clocks, then high → one `uart_rx_error` pulse, `uart_d_out` unchanged, `busy` high until line returns high; a following 8'h81 is received correctly.
- 200-clock low glitch on idle line → false start rejected, no pulse, `busy` drops within one bit time. With `UART_RX_MAJORITY_EN`, a 65-clock glitch at a data bit's tick 8 does not corrupt 8'hFF.
- Assert `uart_reset` for 1 cycle mid-byte → outputs return to reset values, no pulse for the aborted frame; the next full frame 8'h42 is received.
